// File: rtl/udma_adc_ts_pkg.sv
// udma_adc_ts_pkg: shared types and constants for the timestamp uDMA arbiter
package udma_adc_ts_pkg;
  typedef enum logic {IDLE, SEND} arb_state_e;
  localparam logic [1:0] DATASIZE_WORD = 2'b10;
  localparam int DROP_CNT_WIDTH = 8;
endpackage

// File: rtl/udma_adc_ts_rr_pick.sv
// udma_adc_ts_rr_pick: first request at index >= ptr, wrapping modulo NB_CH
module udma_adc_ts_rr_pick #(
  parameter int NB_CH = 4,
  parameter int PW    = 2
) (
  input  logic [NB_CH-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic             gnt_valid,
  output logic [PW-1:0]    gnt_idx
);
  logic [PW:0] s;
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx = '0;
    s = '0;
    for (int k = NB_CH - 1; k >= 0; k--) begin
      s = {1'b0, ptr} + (PW+1)'(k);
      s = (s >= (PW+1)'(NB_CH)) ? s - (PW+1)'(NB_CH) : s;
      if (req[s[PW-1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx = s[PW-1:0];
      end
    end
  end
endmodule

// File: rtl/udma_adc_ts_arbiter.sv
// udma_adc_ts_arbiter: per-channel timestamp slots drained round-robin into one uDMA RX stream
module udma_adc_ts_arbiter
  import udma_adc_ts_pkg::*;
#(
  parameter int NB_CH         = 4,
  parameter int TS_DATA_WIDTH = 28,
  parameter int TS_CHID_WIDTH = 4
) (
  input  logic                             sys_clk_i,
  input  logic                             rst_ni,
  input  logic [NB_CH-1:0]                 cfg_ch_en_i,
  input  logic                             cfg_clr_ovf_i,
  input  logic [NB_CH-1:0]                 ch_valid_i,
  input  logic [NB_CH*TS_DATA_WIDTH-1:0]   ch_data_i,
  output logic [NB_CH-1:0]                 ch_ovf_o,
  output logic [DROP_CNT_WIDTH-1:0]        drop_cnt_o,
  output logic [1:0]                       data_rx_datasize_o,
  output logic [31:0]                      data_rx_o,
  output logic                             data_rx_valid_o,
  input  logic                             data_rx_ready_i
);
  localparam int PW = (NB_CH > 1) ? $clog2(NB_CH) : 1;
  arb_state_e state_q, state_d;
  logic [NB_CH-1:0] full_q, full_d, ovf_q, ovf_d, cap, ovf_ev, gnt_oh;
  logic [TS_DATA_WIDTH-1:0] data_q [NB_CH];
  logic [TS_DATA_WIDTH-1:0] data_d [NB_CH];
  logic [PW-1:0] rr_ptr_q, rr_ptr_d, gnt_idx;
  logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;
  logic [DROP_CNT_WIDTH:0] drop_sum;
  logic [31:0] rx_q, rx_d;
  logic gnt_valid, gnt;
  udma_adc_ts_rr_pick #(.NB_CH(NB_CH), .PW(PW)) u_pick (
    .req       (full_q),
    .ptr       (rr_ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );
  always_comb begin
    gnt = gnt_valid & ((state_q == IDLE) | data_rx_ready_i);
    gnt_oh = gnt ? (NB_CH'(1) << gnt_idx) : '0;
    cap = ch_valid_i & cfg_ch_en_i;
    ovf_ev = cap & full_q & ~gnt_oh;
    full_d = (full_q & ~gnt_oh) | cap;
    for (int i = 0; i < NB_CH; i++)
      data_d[i] = (cap[i] & ~ovf_ev[i]) ? ch_data_i[i*TS_DATA_WIDTH +: TS_DATA_WIDTH] : data_q[i];
    ovf_d = (cfg_clr_ovf_i ? '0 : ovf_q) | ovf_ev;
    drop_sum = (cfg_clr_ovf_i ? '0 : {1'b0, drop_q}) + (DROP_CNT_WIDTH+1)'($countones(ovf_ev));
    drop_d = drop_sum[DROP_CNT_WIDTH] ? '1 : drop_sum[DROP_CNT_WIDTH-1:0];
    rr_ptr_d = !gnt ? rr_ptr_q : (gnt_idx == PW'(NB_CH - 1)) ? '0 : gnt_idx + PW'(1);
    rx_d = rx_q;
    if (gnt) begin
      rx_d = '0;
      rx_d[TS_DATA_WIDTH +: TS_CHID_WIDTH] = TS_CHID_WIDTH'(gnt_idx);
      rx_d[TS_DATA_WIDTH-1:0] = data_q[gnt_idx];
    end
    state_d = gnt ? SEND : ((state_q == SEND) && data_rx_ready_i) ? IDLE : state_q;
  end
  always_ff @(posedge sys_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      full_q <= '0;
      ovf_q <= '0;
      rr_ptr_q <= '0;
      drop_q <= '0;
      rx_q <= '0;
      data_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      full_q <= full_d;
      ovf_q <= ovf_d;
      rr_ptr_q <= rr_ptr_d;
      drop_q <= drop_d;
      rx_q <= rx_d;
      data_q <= data_d;
    end
  end
  assign ch_ovf_o = ovf_q;
  assign drop_cnt_o = drop_q;
  assign data_rx_datasize_o = DATASIZE_WORD;
  assign data_rx_o = rx_q;
  assign data_rx_valid_o = (state_q == SEND);
endmodule

// File: tb/tb_udma_adc_ts_arbiter.sv
// tb_udma_adc_ts_arbiter: directed per-cycle vectors plus hand sequences for multi-cycle corners
module tb_udma_adc_ts_arbiter;
  typedef struct {
    logic        rst;
    logic [3:0]  en;
    logic        clr;
    logic [3:0]  vld;
    logic [27:0] d;
    logic        rdy;
    logic        ev;
    logic        cd;
    logic [31:0] ed;
    logic [3:0]  eovf;
    logic [7:0]  edrop;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] en = '0;
  logic clr = 1'b0;
  logic [3:0] vld = '0;
  logic [111:0] ch_data = '0;
  logic rdy = 1'b0;
  logic [3:0] ovf;
  logic [7:0] drop;
  logic [1:0] dsize;
  logic [31:0] rx;
  logic rx_valid;
  int n = 0;
  int bad = 0;
  vec_t tbl[$];
  always #5 clk = ~clk;
  udma_adc_ts_arbiter #(.NB_CH(4), .TS_DATA_WIDTH(28), .TS_CHID_WIDTH(4)) dut (
    .sys_clk_i          (clk),
    .rst_ni             (rst_n),
    .cfg_ch_en_i        (en),
    .cfg_clr_ovf_i      (clr),
    .ch_valid_i         (vld),
    .ch_data_i          (ch_data),
    .ch_ovf_o           (ovf),
    .drop_cnt_o         (drop),
    .data_rx_datasize_o (dsize),
    .data_rx_o          (rx),
    .data_rx_valid_o    (rx_valid),
    .data_rx_ready_i    (rdy)
  );
  function automatic vec_t mk(logic r, logic [3:0] e, logic c, logic [3:0] v, logic [27:0] d,
                              logic y, logic ev, logic cd, logic [31:0] ed, logic [3:0] eo, logic [7:0] edr);
    vec_t t;
    t.rst = r; t.en = e; t.clr = c; t.vld = v; t.d = d; t.rdy = y;
    t.ev = ev; t.cd = cd; t.ed = ed; t.eovf = eo; t.edrop = edr;
    return t;
  endfunction
  task automatic step(input string nm, input int idx, input vec_t v);
    @(posedge clk);
    #1;
    rst_n = !v.rst;
    en = v.en;
    clr = v.clr;
    vld = v.vld;
    for (int i = 0; i < 4; i++) ch_data[i*28 +: 28] = v.d;
    rdy = v.rdy;
    @(negedge clk);
    n++;
    if (rx_valid !== v.ev || (v.cd && rx !== v.ed) || ovf !== v.eovf || drop !== v.edrop || dsize !== 2'b10) begin
      bad++;
      $display("FAIL %s[%0d]: valid=%b data=%h ovf=%b drop=%0d dsize=%b, want valid=%b data=%h ovf=%b drop=%0d dsize=10",
               nm, idx, rx_valid, rx, ovf, drop, dsize, v.ev, v.ed, v.eovf, v.edrop);
    end
  endtask
  initial begin
    tbl.push_back(mk(1, 4'h2, 0, 4'h0, 28'h0,       1, 0, 1, 32'h0,        4'h0, 8'd0));
    tbl.push_back(mk(0, 4'h2, 0, 4'h2, 28'h1234567, 1, 0, 1, 32'h0,        4'h0, 8'd0));
    tbl.push_back(mk(0, 4'h2, 0, 4'h0, 28'h0,       1, 0, 0, 32'h0,        4'h0, 8'd0));
    tbl.push_back(mk(0, 4'h2, 0, 4'h0, 28'h0,       1, 1, 1, 32'h11234567, 4'h0, 8'd0));
    tbl.push_back(mk(0, 4'h2, 0, 4'h0, 28'h0,       1, 0, 1, 32'h11234567, 4'h0, 8'd0));
    tbl.push_back(mk(1, 4'hF, 0, 4'h0, 28'h0,       1, 0, 1, 32'h0,        4'h0, 8'd0));
    tbl.push_back(mk(0, 4'hF, 0, 4'hF, 28'h0AAAAAA, 1, 0, 0, 32'h0,        4'h0, 8'd0));
    tbl.push_back(mk(0, 4'hF, 0, 4'h0, 28'h0,       1, 0, 0, 32'h0,        4'h0, 8'd0));
    tbl.push_back(mk(0, 4'hF, 0, 4'h0, 28'h0,       1, 1, 1, 32'h00AAAAAA, 4'h0, 8'd0));
    tbl.push_back(mk(0, 4'hF, 0, 4'h0, 28'h0,       1, 1, 1, 32'h10AAAAAA, 4'h0, 8'd0));
    tbl.push_back(mk(0, 4'hF, 0, 4'h0, 28'h0,       1, 1, 1, 32'h20AAAAAA, 4'h0, 8'd0));
    tbl.push_back(mk(0, 4'hF, 0, 4'h9, 28'h0555555, 1, 1, 1, 32'h30AAAAAA, 4'h0, 8'd0));
    tbl.push_back(mk(0, 4'hF, 0, 4'h0, 28'h0,       1, 0, 0, 32'h0,        4'h0, 8'd0));
    tbl.push_back(mk(0, 4'hF, 0, 4'h0, 28'h0,       1, 1, 1, 32'h00555555, 4'h0, 8'd0));
    tbl.push_back(mk(0, 4'hF, 0, 4'h0, 28'h0,       1, 1, 1, 32'h30555555, 4'h0, 8'd0));
    tbl.push_back(mk(0, 4'hF, 0, 4'h0, 28'h0,       1, 0, 0, 32'h0,        4'h0, 8'd0));
    tbl.push_back(mk(0, 4'hF, 0, 4'h4, 28'h0BBBBBB, 0, 0, 0, 32'h0,        4'h0, 8'd0));
    tbl.push_back(mk(0, 4'hF, 0, 4'h0, 28'h0,       0, 0, 0, 32'h0,        4'h0, 8'd0));
    tbl.push_back(mk(0, 4'hF, 0, 4'h0, 28'h0,       0, 1, 1, 32'h20BBBBBB, 4'h0, 8'd0));
    tbl.push_back(mk(0, 4'hF, 0, 4'h4, 28'h0CCCCCC, 0, 1, 1, 32'h20BBBBBB, 4'h0, 8'd0));
    tbl.push_back(mk(0, 4'hF, 0, 4'h0, 28'h0,       0, 1, 1, 32'h20BBBBBB, 4'h0, 8'd0));
    tbl.push_back(mk(0, 4'hF, 0, 4'h4, 28'h0DDDDDD, 0, 1, 1, 32'h20BBBBBB, 4'h0, 8'd0));
    tbl.push_back(mk(0, 4'hF, 0, 4'h0, 28'h0,       0, 1, 1, 32'h20BBBBBB, 4'h4, 8'd1));
    foreach (tbl[k]) step("tbl", k, tbl[k]);
    for (int k = 0; k < 14; k++) step("hold", k, mk(0, 4'hF, 0, 4'h0, 28'h0, 0, 1, 1, 32'h20BBBBBB, 4'h4, 8'd1));
    step("bp_hs", 0, mk(0, 4'hF, 0, 4'h0, 28'h0, 1, 1, 1, 32'h20BBBBBB, 4'h4, 8'd1));
    step("bp_hs", 1, mk(0, 4'hF, 0, 4'h0, 28'h0, 1, 1, 1, 32'h20CCCCCC, 4'h4, 8'd1));
    step("bp_hs", 2, mk(0, 4'hF, 0, 4'h0, 28'h0, 1, 0, 1, 32'h20CCCCCC, 4'h4, 8'd1));
    step("sat", 0, mk(0, 4'hF, 0, 4'h2, 28'h0111111, 0, 0, 0, 32'h0, 4'h4, 8'd1));
    step("sat", 1, mk(0, 4'hF, 0, 4'h2, 28'h0222222, 0, 0, 0, 32'h0, 4'h4, 8'd1));
    step("sat", 2, mk(0, 4'hF, 0, 4'h0, 28'h0, 0, 1, 1, 32'h10111111, 4'h4, 8'd1));
    for (int p = 0; p < 300; p++)
      step("sat_p", p, mk(0, 4'hF, 0, 4'h2, 28'h0333333, 0, 1, 1, 32'h10111111,
                          (p == 0) ? 4'h4 : 4'h6, (p + 1 > 255) ? 8'd255 : 8'(p + 1)));
    step("sat", 3, mk(0, 4'hF, 0, 4'h0, 28'h0, 0, 1, 1, 32'h10111111, 4'h6, 8'd255));
    step("clr", 0, mk(0, 4'hF, 1, 4'h0, 28'h0, 0, 1, 1, 32'h10111111, 4'h6, 8'd255));
    step("clr", 1, mk(0, 4'hF, 0, 4'h0, 28'h0, 0, 1, 1, 32'h10111111, 4'h0, 8'd0));
    step("clr", 2, mk(0, 4'hF, 1, 4'h2, 28'h0444444, 0, 1, 1, 32'h10111111, 4'h0, 8'd0));
    step("clr", 3, mk(0, 4'hF, 0, 4'h0, 28'h0, 0, 1, 1, 32'h10111111, 4'h2, 8'd1));
    step("drain", 0, mk(0, 4'hF, 0, 4'h0, 28'h0, 1, 1, 1, 32'h10111111, 4'h2, 8'd1));
    step("drain", 1, mk(0, 4'hF, 0, 4'h0, 28'h0, 1, 1, 1, 32'h10222222, 4'h2, 8'd1));
    step("drain", 2, mk(0, 4'hF, 1, 4'h0, 28'h0, 1, 0, 0, 32'h0, 4'h2, 8'd1));
    step("drain", 3, mk(0, 4'hF, 0, 4'h0, 28'h0, 1, 0, 0, 32'h0, 4'h0, 8'd0));
    step("same", 0, mk(0, 4'hF, 0, 4'h2, 28'h0123456, 0, 0, 0, 32'h0, 4'h0, 8'd0));
    step("same", 1, mk(0, 4'hF, 0, 4'h1, 28'h0ABCDEF, 0, 0, 0, 32'h0, 4'h0, 8'd0));
    step("same", 2, mk(0, 4'hF, 0, 4'h1, 28'h0FEDCBA, 1, 1, 1, 32'h10123456, 4'h0, 8'd0));
    step("same", 3, mk(0, 4'hF, 0, 4'h0, 28'h0, 1, 1, 1, 32'h00ABCDEF, 4'h0, 8'd0));
    step("same", 4, mk(0, 4'hF, 0, 4'h0, 28'h0, 1, 1, 1, 32'h00FEDCBA, 4'h0, 8'd0));
    step("same", 5, mk(0, 4'hF, 0, 4'h0, 28'h0, 1, 0, 0, 32'h0, 4'h0, 8'd0));
    step("dis", 0, mk(0, 4'h7, 0, 4'h8, 28'h0999999, 1, 0, 0, 32'h0, 4'h0, 8'd0));
    step("dis", 1, mk(0, 4'h7, 0, 4'h8, 28'h0999999, 1, 0, 0, 32'h0, 4'h0, 8'd0));
    step("dis", 2, mk(0, 4'h7, 0, 4'h0, 28'h0, 1, 0, 0, 32'h0, 4'h0, 8'd0));
    step("dis", 3, mk(0, 4'h7, 0, 4'h0, 28'h0, 1, 0, 0, 32'h0, 4'h0, 8'd0));
    step("rst", 0, mk(0, 4'hF, 0, 4'h4, 28'h0777777, 0, 0, 0, 32'h0, 4'h0, 8'd0));
    step("rst", 1, mk(0, 4'hF, 0, 4'h4, 28'h0888888, 0, 0, 0, 32'h0, 4'h0, 8'd0));
    step("rst", 2, mk(0, 4'hF, 0, 4'h0, 28'h0, 0, 1, 1, 32'h20777777, 4'h0, 8'd0));
    #2;
    rst_n = 1'b0;
    #1;
    n++;
    if (rx_valid !== 1'b0 || rx !== 32'h0) begin
      bad++;
      $display("FAIL async_rst: valid=%b data=%h, want valid=0 data=00000000", rx_valid, rx);
    end
    step("rst", 3, mk(1, 4'hF, 0, 4'h0, 28'h0, 1, 0, 1, 32'h0, 4'h0, 8'd0));
    step("rst", 4, mk(0, 4'hF, 0, 4'h0, 28'h0, 1, 0, 1, 32'h0, 4'h0, 8'd0));
    step("rst", 5, mk(0, 4'hF, 0, 4'h0, 28'h0, 1, 0, 1, 32'h0, 4'h0, 8'd0));
    step("rst", 6, mk(0, 4'hF, 0, 4'h0, 28'h0, 1, 0, 1, 32'h0, 4'h0, 8'd0));
    $display("== %0d vectors applied, %0d miscompares ==", n, bad);
    $finish;
  end
endmodule
